// File: rtl/acc_seq_ctrl_pkg.sv
// Shared accelerator constants: controller state encoding and datapath widths
// used by the beat accumulator and its lane adder tree.
package acc_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int NUM_LANES   = 16;
  // Summing 16 lanes grows the result by log2(16) bits.
  localparam int TREE_GROWTH = 4;
  localparam int ACC_W       = 32;

endpackage

// File: rtl/acc_seq_ctrl_adder.sv
// Purely combinational 16-lane signed adder tree; output is
// PRECISION_ADDER+TREE_GROWTH bits wide so no lane sum can overflow.
module acc_16_adder
  import acc_seq_ctrl_pkg::*;
#(
  parameter int PRECISION_ADDER = 16
) (
  input  logic [PRECISION_ADDER*NUM_LANES-1:0]        lanes,
  output logic signed [PRECISION_ADDER+TREE_GROWTH-1:0] sum
);

  localparam int SW = PRECISION_ADDER + TREE_GROWTH;

  logic signed [SW-1:0] lvl0 [NUM_LANES];
  logic signed [SW-1:0] lvl1 [8];
  logic signed [SW-1:0] lvl2 [4];
  logic signed [SW-1:0] lvl3 [2];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_ext
      assign lvl0[gi] = {{TREE_GROWTH{lanes[(gi+1)*PRECISION_ADDER-1]}},
                         lanes[(gi+1)*PRECISION_ADDER-1 -: PRECISION_ADDER]};
    end
    for (gi = 0; gi < 8; gi++) begin : g_l1
      assign lvl1[gi] = lvl0[2*gi] + lvl0[2*gi+1];
    end
    for (gi = 0; gi < 4; gi++) begin : g_l2
      assign lvl2[gi] = lvl1[2*gi] + lvl1[2*gi+1];
    end
    for (gi = 0; gi < 2; gi++) begin : g_l3
      assign lvl3[gi] = lvl2[2*gi] + lvl2[2*gi+1];
    end
  endgenerate

  assign sum = lvl3[0] + lvl3[1];

endmodule

// File: rtl/acc_seq_ctrl.sv
// Job-based accumulator: accepts a beat count, sums the 16-lane tree result of
// every input beat into a 32-bit accumulator, and presents the job total.
module acc_seq_ctrl
  import acc_seq_ctrl_pkg::*;
#(
  parameter int PRECISION_ADDER = 16,
  parameter int LEN_W           = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clr,
  input  logic                                 cfg_valid,
  output logic                                 cfg_ready,
  input  logic [LEN_W-1:0]                     cfg_beats,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [PRECISION_ADDER*NUM_LANES-1:0] in_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic signed [ACC_W-1:0]              out_data,
  output logic                                 busy
);

  localparam int TW = PRECISION_ADDER + TREE_GROWTH;

  state_t                 state;
  state_t                 state_next;
  logic [LEN_W-1:0]       beats_left;
  logic signed [TW-1:0]   tree_sum;
  logic signed [TW-1:0]   psum_q;
  logic                   psum_v;
  logic signed [ACC_W-1:0] acc;

  logic cfg_hs;
  logic in_hs;
  logic out_hs;
  logic last_beat;

  acc_16_adder #(
    .PRECISION_ADDER(PRECISION_ADDER)
  ) u_tree (
    .lanes(in_data),
    .sum  (tree_sum)
  );

  assign cfg_hs    = cfg_valid & cfg_ready;
  assign in_hs     = in_valid & in_ready;
  assign out_hs    = out_valid & out_ready;
  assign last_beat = in_hs && (beats_left == LEN_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else if (clr) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (cfg_hs)    state_next = ST_RUN;
      ST_RUN:   if (last_beat) state_next = ST_DRAIN;
      // The final beat's psum_q is always pending here, so it lands this cycle.
      ST_DRAIN: state_next = ST_DONE;
      ST_DONE:  if (out_hs)    state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      ST_IDLE: begin
        cfg_ready = 1'b1;
        busy      = 1'b0;
      end
      ST_RUN:  in_ready  = 1'b1;
      ST_DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  assign out_data = acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      psum_q     <= '0;
      psum_v     <= 1'b0;
      beats_left <= '0;
    end else if (clr) begin
      acc        <= '0;
      psum_v     <= 1'b0;
      beats_left <= '0;
    end else begin
      psum_v <= in_hs;
      if (in_hs) begin
        psum_q <= tree_sum;
      end

      if (cfg_hs) begin
        beats_left <= (cfg_beats == '0) ? LEN_W'(1) : cfg_beats;
      end else if (in_hs) begin
        beats_left <= beats_left - LEN_W'(1);
      end

      if (cfg_hs) begin
        acc <= '0;
      end else if (psum_v) begin
        acc <= acc + ACC_W'(psum_q);
      end
    end
  end

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Scoreboard bench for acc_seq_ctrl: the driver computes each job's expected
// total from the lane values it sends; a monitor checks results and timing.
module tb_acc_seq_ctrl;

  localparam int P  = 16;
  localparam int LW = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 clr = 1'b0;
  logic                 cfg_valid = 1'b0;
  logic                 cfg_ready;
  logic [LW-1:0]        cfg_beats = '0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [P*16-1:0]      in_data = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic signed [31:0]   out_data;
  logic                 busy;

  acc_seq_ctrl #(
    .PRECISION_ADDER(P),
    .LEN_W          (LW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_beats(cfg_beats),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sum;
    int due;
    int id;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int hs_total = 0;
  int stall_until = 0;
  int job_id = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Consumer back-pressure: random, or held low until stall_until.
  always @(negedge clk) begin
    if (cycle < stall_until) out_ready = 1'b0;
    else out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor samples two time units before each rising edge.
  initial begin : monitor
    bit prev_ov = 1'b0;
    bit prev_or = 1'b0;
    bit idle_pending = 1'b0;
    logic signed [31:0] held = '0;
    forever begin
      @(negedge clk);
      #3;
      if (idle_pending) begin
        chk("idle_after_accept_cfg_ready", cfg_ready, 1);
        chk("idle_after_accept_busy", busy, 0);
        idle_pending = 1'b0;
      end
      if (in_valid && in_ready) hs_total++;
      if (out_valid) begin
        if (!prev_ov) begin
          if (sb.size() == 0) chk("spurious_out_valid", 1, 0);
          else chk($sformatf("job%0d_latency_cycle", sb[0].id), cycle, sb[0].due);
        end else if (!prev_or) begin
          chk("stall_stable_out_data", out_data, held);
        end
        if (out_ready && sb.size() != 0) begin
          chk($sformatf("job%0d_sum", sb[0].id), out_data, sb[0].sum);
          $display("job %0d accepted: out_data=%0d expected=%0d", sb[0].id, out_data, sb[0].sum);
          void'(sb.pop_front());
          idle_pending = 1'b1;
        end
      end
      prev_ov = out_valid;
      prev_or = out_ready;
      held    = out_data;
    end
  end

  function automatic logic [P*16-1:0] pack_lanes(input int l[16]);
    logic [P*16-1:0] d;
    int v;
    d = '0;
    for (int p = 0; p < 16; p++) begin
      v = l[p];
      d[(p+1)*P-1 -: P] = v[P-1:0];
    end
    return d;
  endfunction

  // mode 0: all lanes = val, 1: lane p = p, 2: random full range.
  // gap < 0: random idle cycles between beats, else fixed idle cycles.
  task automatic run_job(input int beats, input int mode, input int val, input int gap,
                         input bit hold_valid, input int abort_after);
    int n;
    int sum;
    int hs0;
    int lanes[16];
    int g;
    int t;
    n   = (beats == 0) ? 1 : beats;
    sum = 0;
    job_id++;
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_beats = LW'(beats);
    for (t = 0; !cfg_ready; t++) begin
      if (t >= 300) begin
        chk("cfg_ready_timeout", 0, 1);
        cfg_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    hs0 = hs_total;
    @(negedge clk);
    cfg_valid = 1'b0;
    for (int b = 0; b < n; b++) begin
      if (b == abort_after) begin
        in_valid = 1'b0;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_cfg_ready", cfg_ready, 1);
        chk("clr_busy", busy, 0);
        chk("clr_out_valid", out_valid, 0);
        chk("clr_out_data", out_data, 0);
        $display("job %0d aborted by clr after %0d beats", job_id, b);
        return;
      end
      g = (gap < 0) ? $urandom_range(0, 2) : gap;
      if (b != 0 || gap >= 0) begin
        for (int i = 0; i < g; i++) begin
          in_valid = 1'b0;
          @(negedge clk);
        end
      end
      for (int p = 0; p < 16; p++) begin
        case (mode)
          0:       lanes[p] = val;
          1:       lanes[p] = p;
          default: lanes[p] = int'($urandom_range(0, 65535)) - 32768;
        endcase
        sum += lanes[p];
      end
      in_valid = 1'b1;
      in_data  = pack_lanes(lanes);
      for (t = 0; !in_ready; t++) begin
        if (t >= 300) begin
          chk("in_ready_timeout", 0, 1);
          in_valid = 1'b0;
          return;
        end
        @(negedge clk);
      end
      if (b == n - 1) sb.push_back('{sum: sum, due: cycle + 2, id: job_id});
      @(negedge clk);
    end
    if (hold_valid) begin
      for (int i = 0; i < 3; i++) begin
        chk("in_ready_after_last_beat", in_ready, 0);
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    chk($sformatf("job%0d_handshakes", job_id), hs_total - hs0, n);
    $display("job %0d issued: beats=%0d expected=%0d", job_id, n, sum);
  endtask

  initial begin : driver
    int t;
    #2;
    chk("reset_cfg_ready", cfg_ready, 1);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_busy", busy, 0);
    #10 rst = 1'b0;

    run_job(1, 0, 1, 0, 0, -1);          // 16
    run_job(4, 0, -32768, 0, 1, -1);     // -2097152, continuous
    stall_until = cycle + 30;
    run_job(3, 1, 0, 1, 0, -1);          // 360, toggled valid, stalled consumer
    run_job(0, 0, 2, 0, 0, -1);          // zero beats act as one: 32
    run_job(5, 0, 3, 0, 0, 2);           // aborted by clr
    run_job(1, 0, 7, 0, 0, -1);          // 112

    // Asynchronous reset in the middle of a job.
    @(negedge clk);
    for (t = 0; !cfg_ready && t < 300; t++) @(negedge clk);
    cfg_valid = 1'b1;
    cfg_beats = LW'(6);
    @(negedge clk);
    cfg_valid = 1'b0;
    in_valid  = 1'b1;
    in_data   = '1;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrun_rst_cfg_ready", cfg_ready, 1);
    chk("midrun_rst_in_ready", in_ready, 0);
    chk("midrun_rst_out_valid", out_valid, 0);
    chk("midrun_rst_out_data", out_data, 0);
    chk("midrun_rst_busy", busy, 0);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    $display("job in flight discarded by rst");

    for (int j = 0; j < 12; j++) begin
      run_job($urandom_range(0, 8), 2, 0, -1, $urandom_range(0, 1), -1);
    end
    run_job(8, 0, 32767, 0, 0, -1);

    for (t = 0; sb.size() != 0 && t < 400; t++) @(negedge clk);
    if (sb.size() != 0) chk("drain_timeout_pending_results", sb.size(), 0);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
